axis_packet_arbiter: RTL and testbench

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

---
 rtl/axis_packet_arbiter.sv | 143 ++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// Packet-locked round-robin arbiter merging N_SRC AXI-Stream byte sources into one output.
// Optional stall watchdog is compiled in with `define ARB_WATCHDOG_EN.
module axis_packet_arbiter #(
  parameter int N_SRC    = 4,
  parameter int DATA_W   = 8,
  parameter int WDOG_CYC = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC*DATA_W-1:0] s_data,
  input  logic [N_SRC-1:0]        s_valid,
  input  logic [N_SRC-1:0]        s_last,
  output logic [N_SRC-1:0]        s_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    wdog_err
);

  localparam int unsigned SW = (N_SRC > 2) ? $clog2(N_SRC) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  if (N_SRC < 2 || N_SRC > 8 || WDOG_CYC < 1) begin : g_bad_param
    $error("axis_packet_arbiter: illegal parameter value");
  end

  logic [0:0]    state, state_nxt;
  logic [SW-1:0] grant, grant_nxt;
  logic [SW-1:0] last_grant, last_grant_nxt;
  logic          pick_found;
  logic [SW-1:0] pick_idx;
  logic          hs;

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0] wdog_cnt, wdog_cnt_nxt;
  logic          wdog_q, wdog_nxt;
`endif

  // Round-robin search starting one past the last granted source
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = (int'(last_grant) + i) % N_SRC;
      if (!pick_found && s_valid[SW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = SW'(idx);
      end
    end
  end

  // Combinational pass-through of the granted source; everything quiet in IDLE
  always_comb begin
    s_ready = '0;
    m_data  = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    if (state == XFER) begin
      m_data         = s_data[int'(grant)*DATA_W +: DATA_W];
      m_valid        = s_valid[grant];
      m_last         = s_last[grant];
      s_ready[grant] = m_ready;
    end
  end

  assign hs = m_valid & m_ready;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
`ifdef ARB_WATCHDOG_EN
    wdog_cnt_nxt   = wdog_cnt;
    wdog_nxt       = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef ARB_WATCHDOG_EN
        wdog_cnt_nxt = '0;
`endif
        if (pick_found) begin
          state_nxt = XFER;
          grant_nxt = pick_idx;
        end
      end
      XFER: begin
        if (hs && m_last) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
`ifdef ARB_WATCHDOG_EN
        // Consecutive stalled cycles of the owner; the limit forces a release
        if (s_valid[grant]) begin
          wdog_cnt_nxt = '0;
        end else if (wdog_cnt == CW'(WDOG_CYC - 1)) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
          wdog_nxt       = 1'b1;
          wdog_cnt_nxt   = '0;
        end else begin
          wdog_cnt_nxt = wdog_cnt + CW'(1);
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SW'(N_SRC - 1);
`ifdef ARB_WATCHDOG_EN
      wdog_cnt   <= '0;
      wdog_q     <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
`ifdef ARB_WATCHDOG_EN
      wdog_cnt   <= wdog_cnt_nxt;
      wdog_q     <= wdog_nxt;
`endif
    end
  end

  assign grant_id = 3'(grant);
  assign busy     = (state == XFER);
`ifdef ARB_WATCHDOG_EN
  assign wdog_err = wdog_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: directed scenarios plus randomized traffic
// checked against a packet-level reference model of the arbitration rules.
module tb_axis_packet_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int WDOG = 16;
  localparam int DEPTH = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_valid, s_last, s_ready;
  logic [W-1:0]   m_data;
  logic           m_valid, m_last, m_ready;
  logic [2:0]     grant_id;
  logic           busy, wdog_err;

  axis_packet_arbiter #(.N_SRC(N), .DATA_W(W), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .grant_id(grant_id), .busy(busy), .wdog_err(wdog_err));

  always #5 clk = ~clk;

  // Source BFMs: per-source beat memory with read/write pointers
  logic [W-1:0] mem [N][DEPTH];
  bit           lst [N][DEPTH];
  int           wr[N], rd[N];
  bit           en[N];
  bit           hs_k[N];

  int n_chk = 0, n_pass = 0;
  int pushed = 0, hs_total = 0;
  // Reference model: current owner (-1 = none), last owner, reported id, stall run
  int m_own, m_lg, m_gid, stall;
  bit exp_wd;
  int n_own, n_lg;
  bit n_wd;
  int log_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_pkt(input int k, input int len, input logic [W-1:0] b0, input bit rnd);
    for (int i = 0; i < len; i++) begin
      mem[k][wr[k]] = rnd ? W'($urandom) : b0 + W'(i);
      lst[k][wr[k]] = (i == len - 1);
      wr[k]++;
      pushed++;
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int lg);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (lg + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      s_valid[k] = en[k] && (rd[k] < wr[k]);
      s_last[k]  = 1'b0;
      s_data[k*W +: W] = '0;
      if (s_valid[k]) begin
        s_last[k]        = lst[k][rd[k]];
        s_data[k*W +: W] = mem[k][rd[k]];
      end
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_lg = N - 1; m_gid = 0; stall = 0; exp_wd = 1'b0;
  endtask

  // One clock cycle: apply inputs, check outputs at negedge, advance model at posedge
  task automatic cycle();
    logic [N-1:0] er;
    bit ev, el;
    logic [W-1:0] ed;
    drive();
    @(negedge clk);
    n_own = m_own; n_lg = m_lg; n_wd = 1'b0;
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("wdog_err", 32'(wdog_err), 32'(exp_wd));
    if (m_own < 0) begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_s_ready", 32'(s_ready), 0);
      chk("idle_m_valid", 32'(m_valid), 0);
      chk("idle_m_last", 32'(m_last), 0);
      chk("idle_m_data", 32'(m_data), 0);
      if (|s_valid) n_own = pick(s_valid, m_lg);
    end else begin
      ev = en[m_own] && (rd[m_own] < wr[m_own]);
      ed = ev ? mem[m_own][rd[m_own]] : '0;
      el = ev ? lst[m_own][rd[m_own]] : 1'b0;
      er = '0;
      er[m_own] = m_ready;
      chk("xfer_busy", 32'(busy), 1);
      chk("xfer_s_ready", 32'(s_ready), 32'(er));
      chk("xfer_m_valid", 32'(m_valid), 32'(ev));
      chk("xfer_m_data", 32'(m_data), 32'(ed));
      chk("xfer_m_last", 32'(m_last), 32'(el));
      if (ev && m_ready) begin
        hs_total++;
        if (el) begin n_own = -1; n_lg = m_own; end
      end
`ifdef ARB_WATCHDOG_EN
      if (!ev) begin
        stall++;
        if (stall == WDOG) begin n_own = -1; n_lg = m_own; n_wd = 1'b1; end
      end else stall = 0;
`endif
    end
    for (int k = 0; k < N; k++) hs_k[k] = s_valid[k] && s_ready[k];
    @(posedge clk);
    #1;
    if (n_own >= 0 && m_own < 0) begin
      m_gid = n_own; stall = 0; log_q.push_back(n_own);
    end
    m_own = n_own; m_lg = n_lg; exp_wd = n_wd;
    for (int k = 0; k < N; k++) if (hs_k[k]) rd[k]++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic bit drained();
    for (int k = 0; k < N; k++) if (rd[k] != wr[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while (!(drained() && m_own < 0) && c < budget) begin
      cycle();
      c++;
    end
    chk(tag, 32'(c < budget), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int st2, h0;
    for (int k = 0; k < N; k++) begin wr[k] = 0; rd[k] = 0; en[k] = 1'b0; end
    m_ready = 1'b0;
    model_reset();
    reset = 1'b1;
    drive();
    #2;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_wdog_err", 32'(wdog_err), 0);
    do_reset();
    cycle();

    // Sources 0 and 2, 3-beat packets, full-rate sink
    for (int k = 0; k < N; k++) en[k] = 1'b1;
    m_ready = 1'b1;
    push_pkt(0, 3, 8'h10, 1'b0);
    push_pkt(2, 3, 8'h20, 1'b0);
    log_q.delete();
    repeat (8) cycle();
    chk("t1_src0_beats", 32'(rd[0]), 3);
    chk("t1_src2_beats", 32'(rd[2]), 3);
    chk("t1_grants", 32'(log_q.size()), 2);
    chk("t1_first", 32'(log_q[0]), 0);
    chk("t1_second", 32'(log_q[1]), 2);
    cycle();
    chk("t1_grant_id_hold", 32'(grant_id), 2);

    // All sources with 1-beat packets from reset: order 0,1,2,3,0
    do_reset();
    push_pkt(0, 1, 8'h30, 1'b0); push_pkt(0, 1, 8'h34, 1'b0);
    push_pkt(1, 1, 8'h31, 1'b0); push_pkt(2, 1, 8'h32, 1'b0); push_pkt(3, 1, 8'h33, 1'b0);
    log_q.delete();
    repeat (10) cycle();
    chk("t2_drained", 32'(drained()), 1);
    chk("t2_grants", 32'(log_q.size()), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), 32'(log_q[i]), 32'(i % N));

    // Source 1 with back-pressure toggling
    push_pkt(1, 1, 8'hA1, 1'b1);
    mem[1][wr[1]-1] = 8'hA1; lst[1][wr[1]-1] = 1'b0;
    push_pkt(1, 1, 8'hA2, 1'b0);
    h0 = hs_total;
    for (int i = 0; i < 5; i++) begin
      m_ready = (i % 2 == 0);
      cycle();
    end
    chk("t3_handshakes", 32'(hs_total - h0), 2);
    chk("t3_src1_done", 32'(drained()), 1);
    m_ready = 1'b1;
    drain("t3_drain", 20);

    // Source 3 stalls mid-packet while source 0 waits
    push_pkt(3, 3, 8'h50, 1'b0);
    push_pkt(0, 1, 8'h60, 1'b0);
    log_q.delete();
    cycle();
    cycle();
    en[3] = 1'b0;
    repeat (20) cycle();
`ifdef ARB_WATCHDOG_EN
    chk("t4_wdog_next_grant", 32'(log_q.size() >= 2 ? log_q[1] : -1), 0);
`else
    chk("t4_busy_held", 32'(busy), 1);
    chk("t4_grant_held", 32'(grant_id), 3);
`endif
    en[3] = 1'b1;
    drain("t4_drain", 40);
    chk("t4_first", 32'(log_q[0]), 3);
    chk("t4_then_src0", 32'(log_q[1]), 0);

    // Reset during beat 2 of a 4-beat packet from source 2
    en[0] = 1'b0;
    st2 = rd[2];
    push_pkt(2, 4, 8'h70, 1'b0);
    cycle();
    cycle();
    drive();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_s_ready", 32'(s_ready), 0);
    chk("t5_rst_m_valid", 32'(m_valid), 0);
    chk("t5_rst_m_last", 32'(m_last), 0);
    chk("t5_rst_m_data", 32'(m_data), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_grant_id", 32'(grant_id), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    hs_total -= rd[2] - st2;
    rd[2] = st2;
    en[0] = 1'b1;
    push_pkt(0, 2, 8'h80, 1'b0);
    log_q.delete();
    drain("t5_drain", 40);
    chk("t5_src0_wins", 32'(log_q[0]), 0);
    chk("t5_src2_resent", 32'(log_q[1]), 2);

    // Randomized traffic with random valid gaps and back-pressure
    for (int k = 0; k < N; k++)
      for (int p = 0; p < 6; p++) push_pkt(k, $urandom_range(1, 4), '0, 1'b1);
    begin
      int c;
      c = 0;
      while (!(drained() && m_own < 0) && c < 3000) begin
        for (int k = 0; k < N; k++) en[k] = ($urandom_range(0, 9) < 8);
        m_ready = ($urandom_range(0, 9) < 7);
        cycle();
        c++;
      end
      chk("rand_drain", 32'(c < 3000), 1);
    end
    chk("total_beats", 32'(hs_total), 32'(pushed));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
